// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - IF-stage PC sequencer with delay-slot jump and exception redirect
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        jumpD,
    input  logic        jump_conflictD,
    input  logic [31:0] pc_jumpD,
    input  logic        flush_excM,
    input  logic [31:0] pc_excM,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        validF
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        pend_j_q, pend_j_d;
    logic [31:0] pend_jpc_q, pend_jpc_d;
    logic        pend_e_q, pend_e_d;
    logic [31:0] pend_epc_q, pend_epc_d;
    logic        discard_q, discard_d;

    logic        fire_j;
    logic        take_jump;
    logic        advance;
    logic [31:0] next_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            valid_q    <= 1'b0;
            pend_j_q   <= 1'b0;
            pend_jpc_q <= 32'd0;
            pend_e_q   <= 1'b0;
            pend_epc_q <= 32'd0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pend_j_q   <= pend_j_d;
            pend_jpc_q <= pend_jpc_d;
            pend_e_q   <= pend_e_d;
            pend_epc_q <= pend_epc_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        // A jump in D is wrong-path whenever an exception is arriving or being applied.
        fire_j    = jumpD & ~jump_conflictD & ~stallD & ~flush_excM & ~pend_e_q;
        take_jump = pend_j_q | fire_j;
        if (pend_e_q) begin
            next_pc = pend_epc_q;
        end else if (take_jump) begin
            next_pc = fire_j ? pc_jumpD : pend_jpc_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end

        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        pend_j_d   = pend_j_q;
        pend_jpc_d = pend_jpc_q;
        pend_e_d   = pend_e_q;
        pend_epc_d = pend_epc_q;
        discard_d  = discard_q;
        advance    = 1'b0;

        if (pend_e_q) begin
            valid_d  = 1'b0;
            pc_d     = pend_epc_q;
            pend_e_d = 1'b0;
            case (state_q)
                S_ADDR: begin
                    if (inst_addr_ok) begin
                        discard_d = 1'b1;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (inst_data_ok) begin
                        discard_d = 1'b0;
                        state_d   = S_ADDR;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_ADDR;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ADDR;
                S_ADDR: begin
                    if (inst_addr_ok) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (inst_data_ok) begin
                        if (discard_q) begin
                            // Stale word from before a redirect: refetch the redirect target.
                            discard_d = 1'b0;
                            state_d   = S_ADDR;
                        end else begin
                            instr_d = inst_rdata;
                            valid_d = 1'b1;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stallF) begin
                        valid_d = 1'b0;
                        pc_d    = next_pc;
                        advance = 1'b1;
                        state_d = S_ADDR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (flush_excM) begin
            pend_e_d   = 1'b1;
            pend_epc_d = pc_excM;
            pend_j_d   = 1'b0;
        end else if (fire_j && !advance) begin
            pend_j_d   = 1'b1;
            pend_jpc_d = pc_jumpD;
        end else if (advance && take_jump) begin
            pend_j_d   = 1'b0;
        end
    end

    assign inst_req  = (state_q == S_ADDR);
    assign inst_addr = pc_q;
    assign pcF       = pc_q;
    assign instrF    = instr_q;
    assign validF    = valid_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - randomized bench for fetch_redirect_unit against a program-flow model
module tb_fetch_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallF, stallD, jumpD, jump_conflictD, flush_excM;
    logic [31:0] pc_jumpD, pc_excM;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [31:0] pcF, instrF;
    logic        validF;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .stallF(stallF), .stallD(stallD),
        .jumpD(jumpD), .jump_conflictD(jump_conflictD), .pc_jumpD(pc_jumpD),
        .flush_excM(flush_excM), .pc_excM(pc_excM),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .pcF(pcF), .instrF(instrF), .validF(validF)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3c1d_0f2a;
    endfunction

    // memory responder
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    logic [31:0] fetch_log[$];

    // program-flow model
    logic [31:0] exp_pc;
    bit          jump_armed;
    logic [31:0] armed_tgt;
    bit          d_valid, d_is_jump;
    logic [31:0] d_tgt;
    int          d_conf;
    int          flush_block;
    bit          flush_req;
    logic [31:0] flush_pc;
    int          consumed;

    // knobs
    int          p_addr, max_lat, p_stall, p_jump, p_flush, hold_stall, force_conf;
    bit          force_en;
    logic [31:0] force_jpc, force_tgt;

    // previous sample
    bit          pv_valid, pv_stall, pv_req, pv_aok;
    logic [31:0] pv_pc, pv_instr, pv_addr;
    int          since_flush;

    function automatic logic [31:0] log_index(input logic [31:0] a);
        foreach (fetch_log[i]) if (fetch_log[i] == a) return i;
        return 32'hffff_ffff;
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic tick();
        bit          consume, fire, flush_now, was_slot;
        logic [31:0] r, cpc;
        @(negedge clk);
        if (since_flush < 100) since_flush++;
        if (since_flush > 2) begin
            if (pv_valid && pv_stall) begin
                check_eq("hold_valid", validF, 1);
                check_eq("hold_pc", pcF, pv_pc);
                check_eq("hold_instr", instrF, pv_instr);
            end
            if (pv_valid && !pv_stall) check_eq("valid_one_cycle", validF, 0);
            if (pv_req && !pv_aok) begin
                check_eq("req_held", inst_req, 1);
                check_eq("addr_stable", inst_addr, pv_addr);
            end
        end
        if (validF)   check_eq("no_req_while_valid", inst_req, 0);
        if (mem_busy) check_eq("no_req_while_busy", inst_req, 0);

        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        if (mem_busy) begin
            if (mem_lat == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = word_of(mem_addr);
                mem_busy     = 1'b0;
            end else begin
                mem_lat--;
            end
        end else if (inst_req && chance(p_addr)) begin
            inst_addr_ok = 1'b1;
            mem_busy     = 1'b1;
            mem_addr     = inst_addr;
            mem_lat      = int'($urandom_range(max_lat));
            fetch_log.push_back(inst_addr);
        end

        r         = $urandom;
        flush_now = 1'b0;
        pc_excM   = {RESET_PC[31:12], r[9:0], 2'b00};
        if (flush_block == 0 && (flush_req || chance(p_flush))) begin
            flush_now = 1'b1;
            if (flush_req) pc_excM = flush_pc;
            flush_req = 1'b0;
        end
        flush_excM     = flush_now;
        jumpD          = 1'b0;
        jump_conflictD = 1'b0;
        pc_jumpD       = $urandom;
        stallD         = chance(p_stall / 3);
        if (d_valid && d_is_jump) begin
            jumpD    = 1'b1;
            pc_jumpD = d_tgt;
            if (d_conf > 0) begin
                jump_conflictD = 1'b1;
                stallD         = 1'b1;
                d_conf--;
            end
        end
        stallF = stallD || flush_now || (flush_block > 0) || chance(p_stall);
        if (hold_stall > 0) begin
            stallF = 1'b1;
            if (validF) hold_stall--;
        end

        fire    = jumpD && !jump_conflictD && !stallD;
        consume = validF && !stallF;
        cpc     = exp_pc;
        if (consume) begin
            check_eq("consume_pc", pcF, exp_pc);
            check_eq("consume_instr", instrF, word_of(exp_pc));
            consumed++;
        end

        if (flush_now) begin
            exp_pc      = pc_excM;
            jump_armed  = 1'b0;
            d_valid     = 1'b0;
            d_is_jump   = 1'b0;
            flush_block = 1;
            since_flush = 0;
        end else begin
            if (flush_block > 0) flush_block--;
            was_slot = 1'b0;
            if (fire) begin
                d_is_jump  = 1'b0;
                jump_armed = 1'b1;
                armed_tgt  = pc_jumpD;
            end
            if (consume) begin
                if (jump_armed) begin
                    exp_pc     = armed_tgt;
                    jump_armed = 1'b0;
                    was_slot   = 1'b1;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (!stallD) begin
                d_valid   = consume;
                d_is_jump = 1'b0;
                if (consume && !was_slot) begin
                    if (force_en && cpc == force_jpc) begin
                        d_is_jump = 1'b1;
                        d_tgt     = force_tgt;
                        d_conf    = force_conf;
                        force_en  = 1'b0;
                    end else if (chance(p_jump)) begin
                        r         = $urandom;
                        d_is_jump = 1'b1;
                        d_tgt     = {RESET_PC[31:12], r[9:0], 2'b00};
                        d_conf    = int'($urandom_range(2));
                    end
                end
            end
        end

        pv_valid = validF;
        pv_stall = stallF;
        pv_req   = inst_req;
        pv_aok   = inst_addr_ok;
        pv_pc    = pcF;
        pv_instr = instrF;
        pv_addr  = inst_addr;
        @(posedge clk);
    endtask

    task automatic clear_inputs();
        stallF = 0; stallD = 0; jumpD = 0; jump_conflictD = 0; flush_excM = 0;
        pc_jumpD = 0; pc_excM = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        mem_busy = 0; exp_pc = RESET_PC; jump_armed = 0; d_valid = 0; d_is_jump = 0;
        flush_block = 0; flush_req = 0; hold_stall = 0; since_flush = 100;
        pv_valid = 0; pv_req = 0; pv_stall = 0; pv_aok = 0;
        fetch_log.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        p_addr = 100; max_lat = 0; p_stall = 0; p_jump = 0; p_flush = 0;
        force_en = 1; force_jpc = 32'hbfc0_0010; force_tgt = 32'hbfc0_0100; force_conf = 0;
        consumed = 0;
        clear_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        @(negedge clk);
        check_eq("reset_pc", pcF, RESET_PC);
        check_eq("reset_valid", validF, 0);
        check_eq("reset_req", inst_req, 0);
        check_eq("reset_instr", instrF, 0);
        do_reset();

        repeat (14) tick();
        check_eq("seq_log_len", fetch_log.size() >= 3, 1);
        if (fetch_log.size() >= 3) begin
            check_eq("seq_fetch0", fetch_log[0], 32'hbfc0_0000);
            check_eq("seq_fetch1", fetch_log[1], 32'hbfc0_0004);
            check_eq("seq_fetch2", fetch_log[2], 32'hbfc0_0008);
        end

        for (int i = 0; i < 60 && log_index(32'hbfc0_0100) == 32'hffff_ffff; i++) tick();
        check_eq("j_slot_then_target", log_index(32'hbfc0_0100) - log_index(32'hbfc0_0014), 1);
        check_eq("j_no_fetch_18", log_index(32'hbfc0_0018), 32'hffff_ffff);

        force_en = 1; force_jpc = 32'hbfc0_0104; force_tgt = 32'hbfc0_0200; force_conf = 2;
        for (int i = 0; i < 80 && log_index(32'hbfc0_0200) == 32'hffff_ffff; i++) tick();
        check_eq("jr_slot_then_target", log_index(32'hbfc0_0200) - log_index(32'hbfc0_0108), 1);
        check_eq("jr_no_fetch_10c", log_index(32'hbfc0_010c), 32'hffff_ffff);

        hold_stall = 3;
        for (int i = 0; i < 30 && hold_stall > 0; i++) tick();
        check_eq("stall_done", hold_stall, 0);
        repeat (6) tick();

        max_lat = 4;
        for (int i = 0; i < 100 && !(mem_busy && !validF && mem_lat >= 2); i++) tick();
        check_eq("flush_setup", mem_busy && !validF && mem_lat >= 2, 1);
        begin
            int n;
            n = fetch_log.size();
            flush_req = 1; flush_pc = 32'hbfc0_0380;
            for (int i = 0; i < 40 && fetch_log.size() <= n; i++) tick();
            check_eq("flush_refetch_len", fetch_log.size() > n, 1);
            if (fetch_log.size() > n) check_eq("flush_refetch_addr", fetch_log[n], 32'hbfc0_0380);
        end
        repeat (20) tick();

        flush_req = 1; flush_pc = 32'hffff_fffc; max_lat = 0;
        for (int i = 0; i < 40 && log_index(32'h0) == 32'hffff_ffff; i++) tick();
        check_eq("wrap_fetch_zero", log_index(32'h0) != 32'hffff_ffff, 1);

        max_lat = 3;
        for (int i = 0; i < 40 && !mem_busy; i++) tick();
        check_eq("rst_setup_busy", mem_busy, 1);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check_eq("rst_mid_pc", pcF, RESET_PC);
        check_eq("rst_mid_valid", validF, 0);
        check_eq("rst_mid_req", inst_req, 0);
        check_eq("rst_mid_instr", instrF, 0);
        do_reset();
        max_lat = 0;
        repeat (8) tick();
        check_eq("rst_restart_len", fetch_log.size() >= 1, 1);
        if (fetch_log.size() >= 1) check_eq("rst_restart_addr", fetch_log[0], RESET_PC);

        p_addr = 60; max_lat = 3; p_stall = 25; p_jump = 20; p_flush = 3;
        consumed = 0;
        repeat (3000) tick();
        check_eq("random_progress", consumed > 100, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
